cache2vias_ctrl: RTL and testbench

Controller that sequences the 2-way cache data array (8 entries, 3-bit data, array address {way, index}) between the CPU and a handshaked backing RAM. Holds tags, valid bits and per-set LRU, and does the hit/miss lookup. Policy: write-through, no-write-allocate. Read misses are filled from RAM. Drives the array's address_cache / dado / dado_ram / hit / writecache inputs and reads its data_out.

---
 rtl/cache2vias_pkg.sv | 26 ++
 rtl/cache2vias_if.sv | 44 ++++
 rtl/cache2vias_tag_store.sv | 59 +++++
 rtl/cache2vias_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_cache2vias_ctrl.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache2vias_pkg.sv
// Shared types and sizes for the 2-way cache controller.
// Optional build macro: CACHE2VIAS_STATS_EN (hit/miss counters).
package cache2vias_pkg;

  localparam int DATA_W  = 3;
  localparam int INDEX_W = 2;
  localparam int TAG_W   = 3;
  localparam int ADDR_W  = TAG_W + INDEX_W;
  localparam int WAYS    = 2;
  localparam int SETS    = 1 << INDEX_W;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WR_HIT,
    RAM_RD,
    FILL,
    RAM_WR,
    RESP
  } state_t;

  function automatic logic other_way(input logic w);
    return ~w;
  endfunction

endpackage

// File: rtl/cache2vias_if.sv
// CPU-side and RAM-side handshake bundles of the cache controller.
// Master drives the request, slave drives the response.
interface cache2vias_cpu_if;
  import cache2vias_pkg::*;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_busy;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata, cpu_busy
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata, cpu_busy
  );
endinterface

interface cache2vias_ram_if;
  import cache2vias_pkg::*;

  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_ready;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    output ram_req, ram_we, ram_addr, ram_wdata,
    input  ram_ready, ram_rdata
  );

  modport slave (
    input  ram_req, ram_we, ram_addr, ram_wdata,
    output ram_ready, ram_rdata
  );
endinterface

// File: rtl/cache2vias_tag_store.sv
// Tags, valid bits and per-set LRU for the 2-way cache.
// Lookup is combinational; updates land on the clock edge.
module cache2vias_tag_store
  import cache2vias_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] lk_idx,
  input  logic [TAG_W-1:0]   lk_tag,
  output logic               hit,
  output logic               hit_way,
  output logic               victim,
  input  logic               upd_way,
  input  logic [INDEX_W-1:0] upd_idx,
  input  logic [TAG_W-1:0]   upd_tag,
  input  logic               set_valid,
  input  logic               touch_lru
);

  logic [WAYS-1:0][SETS-1:0][TAG_W-1:0] tags;
  logic [WAYS-1:0][SETS-1:0]            valid;
  logic [SETS-1:0]                      lru;
  logic                                 m0;
  logic                                 m1;

  // way0 wins when both match; invalid ways never hit
  always_comb begin
    m0      = valid[0][lk_idx] && (tags[0][lk_idx] == lk_tag);
    m1      = valid[1][lk_idx] && (tags[1][lk_idx] == lk_tag);
    hit     = m0 | m1;
    hit_way = !m0 && m1;
    if (!valid[0][lk_idx])
      victim = 1'b0;
    else if (!valid[1][lk_idx])
      victim = 1'b1;
    else
      victim = lru[lk_idx];
  end

  // lru[set] names the way to evict next
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      lru   <= '0;
    end else begin
      if (set_valid)
        valid[upd_way][upd_idx] <= 1'b1;
      if (touch_lru)
        lru[upd_idx] <= other_way(upd_way);
    end
  end

  // tag contents need no reset, the valid bits guard them
  always_ff @(posedge clk) begin
    if (set_valid)
      tags[upd_way][upd_idx] <= upd_tag;
  end

endmodule

// File: rtl/cache2vias_ctrl.sv
// 2-way write-through cache controller, no write-allocate.
// Build macro CACHE2VIAS_STATS_EN adds stat_hits/stat_misses.
module cache2vias_ctrl
  import cache2vias_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  cache2vias_cpu_if.slave    cpu,
  cache2vias_ram_if.master   ram,
  output logic [INDEX_W:0]   address_cache,
  output logic [DATA_W-1:0]  dado,
  output logic [DATA_W-1:0]  dado_ram,
  output logic               hit,
  output logic               writecache,
  input  logic [DATA_W-1:0]  data_out
`ifdef CACHE2VIAS_STATS_EN
  ,
  output logic [7:0]         stat_hits,
  output logic [7:0]         stat_misses
`endif
);

  state_t             state;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [ADDR_W-1:0]  lk_addr;
  logic [INDEX_W-1:0] idx_q;
  logic [TAG_W-1:0]   tag_q;
  logic               ts_hit;
  logic               ts_way;
  logic               ts_victim;
  logic               upd_way;
  logic               set_valid;
  logic               touch_lru;

  assign idx_q        = addr_q[INDEX_W-1:0];
  assign tag_q        = addr_q[ADDR_W-1:INDEX_W];
  assign cpu.cpu_busy = (state != IDLE);

  // look up the incoming address in IDLE so the array
  // address is ready for the LOOKUP cycle
  assign lk_addr = (state == IDLE) ? cpu.cpu_addr : addr_q;

  cache2vias_tag_store u_tags (
    .clk       (clock),
    .rst_n     (reset_n),
    .lk_idx    (lk_addr[INDEX_W-1:0]),
    .lk_tag    (lk_addr[ADDR_W-1:INDEX_W]),
    .hit       (ts_hit),
    .hit_way   (ts_way),
    .victim    (ts_victim),
    .upd_way   (upd_way),
    .upd_idx   (idx_q),
    .upd_tag   (tag_q),
    .set_valid (set_valid),
    .touch_lru (touch_lru)
  );

  // tag store updates: LRU on read hit / write hit, fill on FILL
  always_comb begin
    upd_way   = address_cache[INDEX_W];
    set_valid = 1'b0;
    touch_lru = 1'b0;
    if (state == LOOKUP && ts_hit && !we_q) begin
      upd_way   = ts_way;
      touch_lru = 1'b1;
    end
    if (state == WR_HIT)
      touch_lru = 1'b1;
    if (state == FILL) begin
      set_valid = 1'b1;
      touch_lru = 1'b1;
    end
  end

  // main sequencer with registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      cpu.cpu_ack   <= 1'b0;
      cpu.cpu_rdata <= '0;
      ram.ram_req   <= 1'b0;
      ram.ram_we    <= 1'b0;
      ram.ram_addr  <= '0;
      ram.ram_wdata <= '0;
      address_cache <= '0;
      dado          <= '0;
      dado_ram      <= '0;
      hit           <= 1'b1;
      writecache    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cpu.cpu_req) begin
            we_q          <= cpu.cpu_we;
            addr_q        <= cpu.cpu_addr;
            wdata_q       <= cpu.cpu_wdata;
            address_cache <= {ts_way,
                              cpu.cpu_addr[INDEX_W-1:0]};
            state         <= LOOKUP;
          end
        end
        LOOKUP: begin
          unique case (1'b1)
            (ts_hit && !we_q): begin
              address_cache <= {ts_way, idx_q};
              cpu.cpu_rdata <= data_out;
              cpu.cpu_ack   <= 1'b1;
              state         <= RESP;
            end
            (!ts_hit && !we_q): begin
              ram.ram_req  <= 1'b1;
              ram.ram_we   <= 1'b0;
              ram.ram_addr <= addr_q;
              state        <= RAM_RD;
            end
            (ts_hit && we_q): begin
              address_cache <= {ts_way, idx_q};
              writecache    <= 1'b1;
              hit           <= 1'b1;
              dado          <= wdata_q;
              state         <= WR_HIT;
            end
            default: begin
              ram.ram_req   <= 1'b1;
              ram.ram_we    <= 1'b1;
              ram.ram_addr  <= addr_q;
              ram.ram_wdata <= wdata_q;
              state         <= RAM_WR;
            end
          endcase
        end
        WR_HIT: begin
          writecache    <= 1'b0;
          ram.ram_req   <= 1'b1;
          ram.ram_we    <= 1'b1;
          ram.ram_addr  <= addr_q;
          ram.ram_wdata <= wdata_q;
          state         <= RAM_WR;
        end
        RAM_RD: begin
          if (ram.ram_ready) begin
            ram.ram_req   <= 1'b0;
            dado_ram      <= ram.ram_rdata;
            address_cache <= {ts_victim, idx_q};
            writecache    <= 1'b0;
            hit           <= 1'b0;
            state         <= FILL;
          end
        end
        FILL: begin
          hit           <= 1'b1;
          cpu.cpu_rdata <= dado_ram;
          cpu.cpu_ack   <= 1'b1;
          state         <= RESP;
        end
        RAM_WR: begin
          if (ram.ram_ready) begin
            ram.ram_req <= 1'b0;
            ram.ram_we  <= 1'b0;
            cpu.cpu_ack <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          cpu.cpu_ack <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CACHE2VIAS_STATS_EN
  // saturating hit/miss counters, stepped in LOOKUP
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (state == LOOKUP) begin
      if (ts_hit && stat_hits != 8'hFF)
        stat_hits <= stat_hits + 8'd1;
      if (!ts_hit && stat_misses != 8'hFF)
        stat_misses <= stat_misses + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache2vias_ctrl.sv
// Directed bench for cache2vias_ctrl with a model of the
// 8-entry data array and a hand-driven backing RAM.
module tb_cache2vias_ctrl;
  import cache2vias_pkg::*;

  logic              clk;
  logic              reset_n;
  logic [INDEX_W:0]  address_cache;
  logic [DATA_W-1:0] dado;
  logic [DATA_W-1:0] dado_ram;
  logic              hit;
  logic              writecache;
  logic [DATA_W-1:0] data_out;
  logic [DATA_W-1:0] arr [8];
  int                total;
  int                bad;
  int                wc_cnt;
  int                hz_cnt;
`ifdef CACHE2VIAS_STATS_EN
  logic [7:0]        stat_hits;
  logic [7:0]        stat_misses;
`endif

  cache2vias_cpu_if cpu_bus ();
  cache2vias_ram_if ram_bus ();

  cache2vias_ctrl dut (
    .clock         (clk),
    .reset_n       (reset_n),
    .cpu           (cpu_bus),
    .ram           (ram_bus),
    .address_cache (address_cache),
    .dado          (dado),
    .dado_ram      (dado_ram),
    .hit           (hit),
    .writecache    (writecache),
    .data_out      (data_out)
`ifdef CACHE2VIAS_STATS_EN
    ,
    .stat_hits     (stat_hits),
    .stat_misses   (stat_misses)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign data_out = arr[address_cache];

  // array model: write when writecache=1, or hit=0
  always @(posedge clk) begin
    if (writecache || !hit)
      arr[address_cache] <= writecache ? dado : dado_ram;
    if (writecache) wc_cnt <= wc_cnt + 1;
    if (!hit) hz_cnt <= hz_cnt + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic w,
                       input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d);
    @(negedge clk);
    cpu_bus.cpu_req   = 1'b1;
    cpu_bus.cpu_we    = w;
    cpu_bus.cpu_addr  = a;
    cpu_bus.cpu_wdata = d;
    @(negedge clk);
    cpu_bus.cpu_req   = 1'b0;
  endtask

  task automatic wait_ram(output logic found);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ram_bus.ram_req) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic give_ready(input logic [DATA_W-1:0] rd);
    ram_bus.ram_ready = 1'b1;
    ram_bus.ram_rdata = rd;
    @(negedge clk);
    ram_bus.ram_ready = 1'b0;
  endtask

  task automatic wait_ack(output int cyc, output logic saw_ram);
    cyc     = 0;
    saw_ram = 1'b0;
    while (!cpu_bus.cpu_ack && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (ram_bus.ram_req) saw_ram = 1'b1;
    end
  endtask

  logic found;
  logic saw;
  int   cyc;
  int   wc0;
  int   hz0;

  initial begin
    total = 0;
    bad   = 0;
    wc_cnt = 0;
    hz_cnt = 0;
    for (int i = 0; i < 8; i++) arr[i] = '0;
    reset_n = 1'b0;
    cpu_bus.cpu_req   = 1'b0;
    cpu_bus.cpu_we    = 1'b0;
    cpu_bus.cpu_addr  = '0;
    cpu_bus.cpu_wdata = '0;
    ram_bus.ram_ready = 1'b0;
    ram_bus.ram_rdata = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    chk("rst_ack",   cpu_bus.cpu_ack, 0);
    chk("rst_rdata", cpu_bus.cpu_rdata, 0);
    chk("rst_busy",  cpu_bus.cpu_busy, 0);
    chk("rst_rreq",  ram_bus.ram_req, 0);
    chk("rst_rwe",   ram_bus.ram_we, 0);
    chk("rst_wc",    writecache, 0);
    chk("rst_hit",   hit, 1);
    chk("rst_ac",    address_cache, 0);
    chk("rst_dado",  dado, 0);
    chk("rst_dram",  dado_ram, 0);

    // 1: cold read miss 001_01, RAM returns 110
    issue(1'b0, 5'b001_01, 3'b000);
    chk("m1_busy", cpu_bus.cpu_busy, 1);
    wait_ram(found);
    chk("m1_req",  found, 1);
    chk("m1_we",   ram_bus.ram_we, 0);
    chk("m1_addr", ram_bus.ram_addr, 5'b00101);
    give_ready(3'b110);
    chk("m1_ac",   address_cache, 3'b001);
    chk("m1_wc",   writecache, 0);
    chk("m1_hit",  hit, 0);
    chk("m1_dram", dado_ram, 3'b110);
    wait_ack(cyc, saw);
    chk("m1_lat",  cyc, 1);
    chk("m1_rd",   cpu_bus.cpu_rdata, 3'b110);
    @(negedge clk);
    chk("m1_ack1", cpu_bus.cpu_ack, 0);
    chk("m1_idle", cpu_bus.cpu_busy, 0);

    // 2: read hit 001_01
    issue(1'b0, 5'b001_01, 3'b000);
    wait_ack(cyc, saw);
    chk("h2_lat", cyc, 1);
    chk("h2_ram", saw, 0);
    chk("h2_ac",  address_cache, 3'b001);
    chk("h2_rd",  cpu_bus.cpu_rdata, 3'b110);

    // 3: fill way1, then evict LRU way0, then 001 misses
    issue(1'b0, 5'b010_01, 3'b000);
    wait_ram(found);
    chk("m3a_req", found, 1);
    repeat (2) @(negedge clk);
    chk("m3a_hold", ram_bus.ram_req, 1);
    chk("m3a_addr", ram_bus.ram_addr, 5'b01001);
    give_ready(3'b011);
    chk("m3a_ac", address_cache, 3'b101);
    wait_ack(cyc, saw);
    chk("m3a_rd", cpu_bus.cpu_rdata, 3'b011);

    issue(1'b0, 5'b011_01, 3'b000);
    wait_ram(found);
    chk("m3b_req", found, 1);
    give_ready(3'b111);
    chk("m3b_ac", address_cache, 3'b001);
    wait_ack(cyc, saw);
    chk("m3b_rd", cpu_bus.cpu_rdata, 3'b111);

    issue(1'b0, 5'b001_01, 3'b000);
    wait_ram(found);
    chk("m3c_req", found, 1);
    give_ready(3'b110);
    chk("m3c_ac", address_cache, 3'b101);
    wait_ack(cyc, saw);
    chk("m3c_rd", cpu_bus.cpu_rdata, 3'b110);

    // 4: write hit 011_01 data 100
    issue(1'b1, 5'b011_01, 3'b100);
    @(negedge clk);
    chk("w4_wc",   writecache, 1);
    chk("w4_hit",  hit, 1);
    chk("w4_dado", dado, 3'b100);
    chk("w4_ac",   address_cache, 3'b001);
    wait_ram(found);
    chk("w4_req",   found, 1);
    chk("w4_we",    ram_bus.ram_we, 1);
    chk("w4_wdata", ram_bus.ram_wdata, 3'b100);
    chk("w4_addr",  ram_bus.ram_addr, 5'b01101);
    chk("w4_wc0",   writecache, 0);
    give_ready(3'b000);
    wait_ack(cyc, saw);
    chk("w4_ack", cpu_bus.cpu_ack, 1);
    @(negedge clk);

    issue(1'b0, 5'b011_01, 3'b000);
    wait_ack(cyc, saw);
    chk("h4_ram", saw, 0);
    chk("h4_rd",  cpu_bus.cpu_rdata, 3'b100);

    // 5: write miss 111_10 data 010, array untouched
    wc0 = wc_cnt;
    hz0 = hz_cnt;
    issue(1'b1, 5'b111_10, 3'b010);
    wait_ram(found);
    chk("w5_req",   found, 1);
    chk("w5_we",    ram_bus.ram_we, 1);
    chk("w5_wdata", ram_bus.ram_wdata, 3'b010);
    chk("w5_addr",  ram_bus.ram_addr, 5'b11110);
    give_ready(3'b000);
    wait_ack(cyc, saw);
    chk("w5_ack", cpu_bus.cpu_ack, 1);
    @(negedge clk);
    chk("w5_wcn", wc_cnt - wc0, 0);
    chk("w5_hzn", hz_cnt - hz0, 0);

    // set 2 still invalid; a request while busy is dropped
    issue(1'b0, 5'b111_10, 3'b000);
    wait_ram(found);
    chk("m5_req", found, 1);
    cpu_bus.cpu_req  = 1'b1;
    cpu_bus.cpu_addr = 5'b000_11;
    @(negedge clk);
    cpu_bus.cpu_req  = 1'b0;
    give_ready(3'b001);
    chk("m5_ac", address_cache, 3'b010);
    wait_ack(cyc, saw);
    chk("m5_rd", cpu_bus.cpu_rdata, 3'b001);
    repeat (2) @(negedge clk);
    chk("m5_idle", cpu_bus.cpu_busy, 0);

    // 6: reset during RAM_RD
    issue(1'b0, 5'b100_01, 3'b000);
    wait_ram(found);
    chk("r6_req", found, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("r6_rreq0", ram_bus.ram_req, 0);
    chk("r6_wc0",   writecache, 0);
    chk("r6_ack0",  cpu_bus.cpu_ack, 0);
    @(negedge clk);
    reset_n = 1'b1;
    give_ready(3'b111);
    chk("r6_late_req",  ram_bus.ram_req, 0);
    chk("r6_late_busy", cpu_bus.cpu_busy, 0);
    chk("r6_late_hit",  hit, 1);

    issue(1'b0, 5'b001_01, 3'b000);
    wait_ram(found);
    chk("r6_miss", found, 1);
    give_ready(3'b101);
    chk("r6_ac", address_cache, 3'b001);
    wait_ack(cyc, saw);
    chk("r6_rd", cpu_bus.cpu_rdata, 3'b101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
